// File: rtl/axi4_lite_master.sv
// AXI4-Lite master: turns a single-outstanding command/response handshake into AXI4-Lite
// read or write transactions. AW and W are issued together and retire independently.
module axi4_lite_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_SIZE  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_clk_ni,
  // Command interface
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr_i,
  input  logic [DATA_SIZE-1:0]     cmd_wdata_i,
  input  logic [DATA_SIZE/8-1:0]   cmd_wstrb_i,
  // Response interface
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [DATA_SIZE-1:0]     rsp_rdata_o,
  output logic [1:0]               rsp_resp_o,
  // AW channel
  output logic [ADDR_WIDTH-1:0]    awaddr_o,
  output logic                     awvalid_o,
  input  logic                     awready_i,
  // W channel
  output logic [DATA_SIZE-1:0]     wdata_o,
  output logic [DATA_SIZE/8-1:0]   wstrb_o,
  output logic                     wvalid_o,
  input  logic                     wready_i,
  // B channel
  input  logic [1:0]               bresp_i,
  input  logic                     bvalid_i,
  output logic                     bready_o,
  // AR channel
  output logic [ADDR_WIDTH-1:0]    araddr_o,
  output logic                     arvalid_o,
  input  logic                     arready_i,
  // R channel
  input  logic [DATA_SIZE-1:0]     rdata_i,
  input  logic [1:0]               rresp_i,
  input  logic                     rvalid_i,
  output logic                     rready_o
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWresp,
    StRaddr,
    StRdata,
    StRsp
  } state_e;

  state_e                   r_state;
  state_e                   w_state_next;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [DATA_SIZE-1:0]     r_wdata;
  logic [DATA_SIZE/8-1:0]   r_wstrb;
  logic                     r_awvalid;
  logic                     r_wvalid;
  logic [DATA_SIZE-1:0]     r_rdata;
  logic [1:0]               r_resp;

  logic w_cmd_hs;
  logic w_aw_done;
  logic w_w_done;

  assign w_cmd_hs  = (r_state == StIdle) && cmd_valid_i;
  // A channel counts as done if it already handshook or is handshaking this cycle.
  assign w_aw_done = !r_awvalid || awready_i;
  assign w_w_done  = !r_wvalid || wready_i;

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk_i or negedge rst_clk_ni) begin
    if (!rst_clk_ni) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (cmd_valid_i) w_state_next = cmd_write_i ? StWrite : StRaddr;
      StWrite: if (w_aw_done && w_w_done) w_state_next = StWresp;
      StWresp: if (bvalid_i) w_state_next = StRsp;
      StRaddr: if (arready_i) w_state_next = StRdata;
      StRdata: if (rvalid_i) w_state_next = StRsp;
      StRsp:   if (rsp_ready_i) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Command capture, per-channel valid tracking and response capture.
  always_ff @(posedge clk_i or negedge rst_clk_ni) begin
    if (!rst_clk_ni) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_rdata   <= '0;
      r_resp    <= '0;
    end else begin
      if (w_cmd_hs) begin
        r_addr    <= cmd_addr_i;
        r_wdata   <= cmd_wdata_i;
        r_wstrb   <= cmd_wstrb_i;
        r_awvalid <= cmd_write_i;
        r_wvalid  <= cmd_write_i;
      end
      if (r_state == StWrite) begin
        if (awready_i) r_awvalid <= 1'b0;
        if (wready_i)  r_wvalid  <= 1'b0;
      end
      if ((r_state == StWresp) && bvalid_i) begin
        r_resp  <= bresp_i;
        r_rdata <= '0;
      end
      if ((r_state == StRdata) && rvalid_i) begin
        r_resp  <= rresp_i;
        r_rdata <= rdata_i;
      end
    end
  end

  assign cmd_ready_o = (r_state == StIdle);
  assign awaddr_o    = r_addr;
  assign awvalid_o   = r_awvalid;
  assign wdata_o     = r_wdata;
  assign wstrb_o     = r_wstrb;
  assign wvalid_o    = r_wvalid;
  assign bready_o    = (r_state == StWresp);
  assign araddr_o    = r_addr;
  assign arvalid_o   = (r_state == StRaddr);
  assign rready_o    = (r_state == StRdata);
  assign rsp_valid_o = (r_state == StRsp);
  assign rsp_rdata_o = r_rdata;
  assign rsp_resp_o  = r_resp;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master: a vector table drives a per-cycle slave model with
// programmable ready/valid delays, plus a hand-written reset-during-WRESP sequence.
module tb_axi4_lite_master;

  logic        clk_i = 1'b0;
  logic        rst_clk_ni;
  logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic [3:0]  cmd_wstrb_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  rsp_resp_o;
  logic [31:0] awaddr_o;
  logic        awvalid_o, awready_i;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wvalid_o, wready_i;
  logic [1:0]  bresp_i;
  logic        bvalid_i, bready_o;
  logic [31:0] araddr_o;
  logic        arvalid_o, arready_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rvalid_i, rready_o;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk_i = ~clk_i;

  axi4_lite_master #(.ADDR_WIDTH(32), .DATA_SIZE(32)) dut (
    .clk_i(clk_i), .rst_clk_ni(rst_clk_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_resp_o(rsp_resp_o),
    .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    int          ar_dly;
    int          r_dly;
    int          hold;      // cycles rsp_ready_i is held low
    logic        eager;     // slave drives bvalid/rvalid high at all times
    logic [31:0] sdata;
    logic [1:0]  resp;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    cmd_valid_i = 0; cmd_write_i = 0; cmd_addr_i = '0; cmd_wdata_i = '0; cmd_wstrb_i = '0;
    rsp_ready_i = 0; awready_i = 0; wready_i = 0; bresp_i = '0; bvalid_i = 0;
    arready_i = 0; rdata_i = '0; rresp_i = '0; rvalid_i = 0;
  endtask

  // Runs one transaction from a negedge; inputs change and outputs are sampled on negedges.
  task automatic run_vec(input vec_t v, output int lat, output logic [31:0] rdata,
                         output logic [1:0] resp, output int aw_cyc, output int w_cyc,
                         output int ar_cyc, output int rsp_cyc, output int viol,
                         output logic done);
    int   cyc, hs, b_cnt, r_cnt;
    logic p_aw, p_awr, p_w, p_wr, p_ar, p_arr;
    lat = -1; rdata = '0; resp = '0; aw_cyc = 0; w_cyc = 0; ar_cyc = 0; rsp_cyc = 0;
    viol = 0; done = 0; cyc = 0; hs = -1; b_cnt = 0; r_cnt = 0;
    p_aw = 0; p_awr = 0; p_w = 0; p_wr = 0; p_ar = 0; p_arr = 0;
    cmd_valid_i = 1; cmd_write_i = v.write; cmd_addr_i = v.addr;
    cmd_wdata_i = v.wdata; cmd_wstrb_i = v.wstrb;
    while (!done && cyc < 100) begin
      if (hs >= 0) begin
        cmd_valid_i = 0;
        if (cmd_ready_o) viol++;
      end else if (cmd_ready_o) begin
        hs = cyc;
      end
      if ((p_aw && !p_awr && !awvalid_o) || (p_w && !p_wr && !wvalid_o) ||
          (p_ar && !p_arr && !arvalid_o)) viol++;
      if (awvalid_o) begin
        aw_cyc++;
        if (awaddr_o !== v.addr) viol++;
      end
      awready_i = awvalid_o && (aw_cyc > v.aw_dly);
      if (wvalid_o) begin
        w_cyc++;
        if (wdata_o !== v.wdata || wstrb_o !== v.wstrb) viol++;
      end
      wready_i = wvalid_o && (w_cyc > v.w_dly);
      if (arvalid_o) begin
        ar_cyc++;
        if (araddr_o !== v.addr) viol++;
      end
      arready_i = arvalid_o && (ar_cyc > v.ar_dly);
      if (bready_o) begin
        b_cnt++;
        if (awvalid_o || wvalid_o) viol++;
      end
      bvalid_i = v.eager || (bready_o && b_cnt > v.b_dly);
      bresp_i  = v.resp;
      if (rready_o) r_cnt++;
      rvalid_i = v.eager || (rready_o && r_cnt > v.r_dly);
      rdata_i  = v.sdata;
      rresp_i  = v.resp;
      rsp_ready_i = 0;
      if (rsp_valid_o) begin
        rsp_cyc++;
        if (lat < 0) begin
          lat = cyc - hs; rdata = rsp_rdata_o; resp = rsp_resp_o;
        end else if (rsp_rdata_o !== rdata || rsp_resp_o !== resp) begin
          viol++;
        end
        if (rsp_cyc > v.hold) begin
          rsp_ready_i = 1; done = 1;
        end
      end
      p_aw = awvalid_o; p_awr = awready_i; p_w = wvalid_o; p_wr = wready_i;
      p_ar = arvalid_o; p_arr = arready_i;
      @(negedge clk_i);
      cyc++;
    end
    idle_inputs();
  endtask

  task automatic do_vec(input string tag, input vec_t v);
    int lat, aw_cyc, w_cyc, ar_cyc, rsp_cyc, viol;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        done;
    run_vec(v, lat, rdata, resp, aw_cyc, w_cyc, ar_cyc, rsp_cyc, viol, done);
    chk({tag, " completed"}, done, 1);
    chk({tag, " latency"}, lat, v.exp_lat);
    chk({tag, " rdata"}, rdata, v.exp_rdata);
    chk({tag, " resp"}, resp, v.exp_resp);
    chk({tag, " protocol/stability violations"}, viol, 0);
    chk({tag, " rsp_valid cycles"}, rsp_cyc, v.hold + 1);
    if (v.write) begin
      chk({tag, " awvalid cycles"}, aw_cyc, v.aw_dly + 1);
      chk({tag, " wvalid cycles"}, w_cyc, v.w_dly + 1);
      chk({tag, " arvalid cycles"}, ar_cyc, 0);
    end else begin
      chk({tag, " arvalid cycles"}, ar_cyc, v.ar_dly + 1);
      chk({tag, " aw+w valid cycles"}, aw_cyc + w_cyc, 0);
    end
  endtask

  initial begin
    int seen;
    //          wr   addr      wdata         strb  aw w  b  ar r  hold eager sdata  resp
    //          lat rdata       resp
    vecs[0] = '{1'b1, 32'h4,  32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0, 1'b0, 32'h0, 2'd0,
                3, 32'h0,        2'd0};
    vecs[1] = '{1'b0, 32'h8,  32'h0,        4'h0, 0, 0, 0, 4, 0, 0, 1'b0, 32'h12345678, 2'd0,
                7, 32'h12345678, 2'd0};
    vecs[2] = '{1'b1, 32'h10, 32'h0000ABCD, 4'h3, 3, 0, 0, 0, 0, 1, 1'b0, 32'h0, 2'd0,
                6, 32'h0,        2'd0};
    vecs[3] = '{1'b1, 32'h20, 32'h11223344, 4'h8, 0, 2, 1, 0, 0, 0, 1'b0, 32'h0, 2'd3,
                6, 32'h0,        2'd3};
    vecs[4] = '{1'b0, 32'hC,  32'h0,        4'h0, 0, 0, 0, 0, 2, 5, 1'b0, 32'hA5A5A5A5, 2'd2,
                5, 32'hA5A5A5A5, 2'd2};
    vecs[5] = '{1'b0, 32'h0,  32'h0,        4'h0, 0, 0, 0, 1, 0, 0, 1'b1, 32'hCAFEF00D, 2'd0,
                4, 32'hCAFEF00D, 2'd0};
    vecs[6] = '{1'b1, 32'h44, 32'hFFFF0000, 4'hC, 1, 1, 0, 0, 0, 0, 1'b1, 32'h5555AAAA, 2'd1,
                4, 32'h0,        2'd1};

    idle_inputs();
    rst_clk_ni = 0;
    repeat (2) @(negedge clk_i);
    chk("reset cmd_ready", cmd_ready_o, 1);
    chk("reset valids/readys",
        {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, rsp_valid_o}, 6'b0);
    chk("reset addr/data", {awaddr_o, araddr_o, wdata_o, wstrb_o}, 0);
    chk("reset rsp fields", {rsp_rdata_o, rsp_resp_o}, 0);
    rst_clk_ni = 1;
    @(negedge clk_i);

    for (int i = 0; i < 7; i++) do_vec($sformatf("v%0d", i), vecs[i]);

    // Reset while waiting in WRESP: write accepted, slave withholds bvalid.
    cmd_valid_i = 1; cmd_write_i = 1; cmd_addr_i = 32'h80;
    cmd_wdata_i = 32'h0BADF00D; cmd_wstrb_i = 4'hF;
    awready_i = 1; wready_i = 1;
    @(negedge clk_i);
    cmd_valid_i = 0;
    @(negedge clk_i);
    chk("mid-reset reached WRESP", bready_o, 1);
    rst_clk_ni = 0;
    #1;
    chk("mid-reset cmd_ready", cmd_ready_o, 1);
    chk("mid-reset valids/readys",
        {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, rsp_valid_o}, 6'b0);
    chk("mid-reset awaddr", awaddr_o, 0);
    idle_inputs();
    bvalid_i = 1; bresp_i = 2'd2;
    @(negedge clk_i);
    rst_clk_ni = 1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      if (rsp_valid_o) seen++;
    end
    chk("after reset no response", seen, 0);
    chk("after reset idle", cmd_ready_o, 1);
    idle_inputs();
    @(negedge clk_i);
    do_vec("post-reset v0", vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
